alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised, pipelined successor to the single-cycle 8-bit ALU. Takes operand
//  pairs over a valid/ready handshake, computes one of eight ops, and returns the
//  result with Z/N/C/V flags two cycles later. An internal accumulator can replace
//  operand A for running sums. The tri-state output enable is retained. Sits
//  between the datapath register file and any consumer that may stall.
// PARAMETERS
//  WIDTH   8                  operand/result width (>=4)
//  SHW     $clog2(WIDTH)      shift-amount width, derived; do not override
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block can accept a beat
//  op         in   3      operation code (see BEHAVIOUR)
//  a, b       in   WIDTH  operands (unsigned; V flag uses a signed view)
//  acc_sel    in   1      1: use accumulator in place of a
//  acc_clr    in   1      synchronous accumulator clear, no handshake
//  out_valid  out  1      result beat valid
//  out_ready  in   1      consumer accepts the beat
//  y          out  WIDTH  result; 'z when oe=0
//  flags      out  4      {Z,N,C,V}
//  oe         in   1      output enable for y only (flags and valid are never 'z)
// BEHAVIOUR
//  Ops: 000 ADD, 001 SUB, 010 AND, 011 NOT A, 100 OR, 101 XOR,
//       110 SHL a by b[SHW-1:0], 111 SHR logical, same amount.
//  Width rules:
//   - ADD: C = carry-out bit WIDTH.
//   - SUB: C = borrow (a<b unsigned).
//   - V = signed overflow for ADD/SUB, 0 otherwise.
//   - Shifts: C = last bit shifted out; C = 0 for amount 0.
//   - Logic ops: C = V = 0.
//   - Z = (y==0); N = y[WIDTH-1].
//  Pipeline: two stages.
//   - S1 registers {op, a, b, acc_sel}.
//   - S2 computes and registers {y, flags}.
//   - Accepted beat -> out_valid exactly 2 cycles later when unstalled.
//   - Throughput is 1 beat/clk.
//  Handshake:
//   - A beat transfers when valid & ready are both high in the same cycle.
//   - S2 advances if !s2_valid | out_ready.
//   - S1 advances if !s1_valid | S2 advances.
//   - in_ready = S1 advances (combinational from state and out_ready).
//   - out_valid, y and flags stay stable while out_valid & !out_ready.
//   - Beats are never dropped or duplicated.
//  Accumulator:
//   - acc <= y on every S1->S2 transfer.
//   - With acc_sel=1 the computation uses the acc value present at that transfer.
//     Back-to-back acc_sel beats therefore chain with no bubble.
//   - acc_clr=1 forces acc <= 0 next edge; this has priority over a simultaneous
//     update. A beat computed in that same cycle still uses the old acc.
//  Reset (async assert, sync release inside the flops):
//   - s1_valid = s2_valid = 0, acc = 0, y register = 0, flags = 0, out_valid = 0.
//   - in_ready = 1 from the first cycle after release.
//   - Reset mid-operation discards all in-flight beats.
//  oe only gates y; the pipeline runs identically with oe=0.
// STRUCTURE
//  Package alu_pipe_pkg:
//   - op localparams OP_ADD..OP_SHR.
//   - flag index localparams F_Z, F_N, F_C, F_V.
//  Sub-module alu_pipe_core: purely combinational {y, flags} = f(op, a_eff, b),
//  parametrised by WIDTH. The top holds the stage registers, handshake and acc.
// TESTING
//  1. Reset, then one beat ADD a=8'hF0 b=8'h20 -> out_valid at +2 clk,
//     y=8'h10, flags={0,0,1,0}.
//  2. SUB 8'h7F-8'hFF -> y=8'h80, C=1, V=1, N=1.
//     SHL 8'h81 by 1 -> y=8'h02, C=1.
//     SHR by 0 -> y=a, C=0.
//  3. Hold out_ready=0 with 3 beats sent:
//     - in_ready drops after the 2nd beat.
//     - y/flags hold stable.
//     - Release -> beats emerge in order, none lost.
//  4. acc_clr, then 4 back-to-back ADD acc_sel=1 b=8'd5 -> y=5,10,15,20
//     on consecutive cycles.
//  5. acc_clr in the same cycle as an acc_sel transfer -> that result uses the old
//     acc; the next acc_sel beat sees acc=0.
//  6. Assert rst_n=0 with 2 beats in flight -> out_valid=0, flags=0 immediately
//     and no stale beat after release. Also check oe=0 -> y='z while out_valid
//     still toggles.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// Shared opcode and flag-index constants for the pipelined ALU.
package alu_pipe_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    // flags vector is {Z,N,C,V}
    localparam int F_Z = 3;
    localparam int F_N = 2;
    localparam int F_C = 1;
    localparam int F_V = 0;

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath: {y, flags} as a pure function of op and operands.
module alu_pipe_core
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o,
    output logic [3:0]       flags_o
);

    logic [WIDTH:0]   ext;
    logic [SHW-1:0]   amt;
    logic             c;
    logic             v;

    assign amt = b_i[SHW-1:0];

    always_comb begin
        ext = '0;
        y_o = '0;
        c   = 1'b0;
        v   = 1'b0;
        unique case (op_i)
            OP_ADD: begin
                ext = {1'b0, a_i} + {1'b0, b_i};
                y_o = ext[WIDTH-1:0];
                c   = ext[WIDTH];
                v   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (y_o[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB: begin
                // bit WIDTH of the extended difference is the borrow
                ext = {1'b0, a_i} - {1'b0, b_i};
                y_o = ext[WIDTH-1:0];
                c   = ext[WIDTH];
                v   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (y_o[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_AND: y_o = a_i & b_i;
            OP_NOT: y_o = ~a_i;
            OP_OR:  y_o = a_i | b_i;
            OP_XOR: y_o = a_i ^ b_i;
            OP_SHL: begin
                // spare bit above the MSB catches the last bit shifted out
                ext = {1'b0, a_i} << amt;
                y_o = ext[WIDTH-1:0];
                c   = ext[WIDTH];
            end
            OP_SHR: begin
                ext = {a_i, 1'b0} >> amt;
                y_o = ext[WIDTH:1];
                c   = ext[0];
            end
            default: y_o = '0;
        endcase
    end

    always_comb begin
        flags_o      = '0;
        flags_o[F_Z] = (y_o == '0);
        flags_o[F_N] = y_o[WIDTH-1];
        flags_o[F_C] = c;
        flags_o[F_V] = v;
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline with a running accumulator and tri-state result.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_sel,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       flags,
    input  logic             oe
);

    logic             s1_valid_q;
    logic [2:0]       s1_op_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic             s1_acc_sel_q;

    logic             s2_valid_q;
    logic [WIDTH-1:0] y_q;
    logic [3:0]       flags_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;

    logic             s1_adv;
    logic             s2_adv;
    logic             s1_xfer;
    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] y_d;
    logic [3:0]       flags_d;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign s1_xfer  = s1_valid_q && s2_adv;
    assign in_ready = s1_adv;

    // acc is sampled at the S1->S2 transfer, so chained acc_sel beats need no bubble
    assign a_eff = s1_acc_sel_q ? acc_q : s1_a_q;

    alu_pipe_core #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_core (
        .op_i    (s1_op_q),
        .a_i     (a_eff),
        .b_i     (s1_b_q),
        .y_o     (y_d),
        .flags_o (flags_d)
    );

    always_comb begin
        acc_d = acc_q;
        if (acc_clr)
            acc_d = '0;
        else if (s1_xfer)
            acc_d = y_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_op_q      <= OP_ADD;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_acc_sel_q <= 1'b0;
            s2_valid_q   <= 1'b0;
            y_q          <= '0;
            flags_q      <= '0;
            acc_q        <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_op_q      <= op;
                    s1_a_q       <= a;
                    s1_b_q       <= b;
                    s1_acc_sel_q <= acc_sel;
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    y_q     <= y_d;
                    flags_q <= flags_d;
                end
            end
            acc_q <= acc_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign flags     = flags_q;
    assign y         = oe ? y_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vector table, handshake corner sequences, random vs model.
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    typedef struct packed {
        logic [7:0] y;
        logic [3:0] f;
    } exp_t;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] ey;
        logic [3:0] ef;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       acc_sel;
    logic       acc_clr;
    logic       out_valid;
    logic       out_ready;
    wire  [7:0] y;
    logic [3:0] flags;
    logic       oe;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    exp_t man_q[$];
    int   pop_cyc[$];
    logic [7:0] model_acc = 8'h00;
    vec_t vt[16];

    alu_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .acc_sel   (acc_sel),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .flags     (flags),
        .oe        (oe)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference ALU from the arithmetic definitions, using plain integers.
    function automatic exp_t ref_alu(input logic [2:0] o, input logic [7:0] x, input logic [7:0] w);
        exp_t e;
        int ux, uw, sx, sw, r, s, amt;
        bit c, v;
        ux = int'(x);  uw = int'(w);
        sx = int'($signed(x));  sw = int'($signed(w));
        amt = int'(w[2:0]);
        c = 1'b0;  v = 1'b0;  r = 0;
        case (o)
            OP_ADD: begin r = ux + uw; c = (r > 255); s = sx + sw; v = (s > 127) || (s < -128); end
            OP_SUB: begin r = ux - uw; c = (ux < uw); s = sx - sw; v = (s > 127) || (s < -128); end
            OP_AND: r = ux & uw;
            OP_NOT: r = ~ux;
            OP_OR:  r = ux | uw;
            OP_XOR: r = ux ^ uw;
            OP_SHL: begin r = ux << amt; c = (amt != 0) && (((ux >> (8 - amt)) & 1) == 1); end
            default: begin r = ux >> amt; c = (amt != 0) && (((ux >> (amt - 1)) & 1) == 1); end
        endcase
        e.y = r[7:0];
        e.f = {(e.y == 8'h00), e.y[7], c, v};
        return e;
    endfunction

    // One clock: record accepted beats, check any presented result, advance to #1 past the edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (in_valid && in_ready) begin
            if (man_q.size() > 0) e = man_q.pop_front();
            else                  e = ref_alu(op, acc_sel ? model_acc : a, b);
            model_acc = e.y;
            exp_q.push_back(e);
        end
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_beat", 32'd1, 32'd0);
            end else begin
                if (oe) chk("y", {24'd0, y}, {24'd0, exp_q[0].y});
                chk("flags", {28'd0, flags}, {28'd0, exp_q[0].f});
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    pop_cyc.push_back(cyc);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget && exp_q.size() > 0; k++) step();
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic beat(input logic [2:0] o, input logic [7:0] x, input logic [7:0] w, input logic s);
        in_valid = 1'b1; op = o; a = x; b = w; acc_sel = s;
    endtask

    initial begin
        vt[0]  = '{OP_ADD, 8'hF0, 8'h20, 8'h10, 4'b0010};
        vt[1]  = '{OP_SUB, 8'h7F, 8'hFF, 8'h80, 4'b0111};
        vt[2]  = '{OP_SHL, 8'h81, 8'h01, 8'h02, 4'b0010};
        vt[3]  = '{OP_SHR, 8'hA5, 8'hF8, 8'hA5, 4'b0100};
        vt[4]  = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b0101};
        vt[5]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b1010};
        vt[6]  = '{OP_SUB, 8'h05, 8'h05, 8'h00, 4'b1000};
        vt[7]  = '{OP_SUB, 8'h80, 8'h01, 8'h7F, 4'b0001};
        vt[8]  = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 4'b0000};
        vt[9]  = '{OP_NOT, 8'h0F, 8'h77, 8'hF0, 4'b0100};
        vt[10] = '{OP_OR,  8'h00, 8'h00, 8'h00, 4'b1000};
        vt[11] = '{OP_XOR, 8'hAA, 8'h55, 8'hFF, 4'b0100};
        vt[12] = '{OP_SHR, 8'h81, 8'h01, 8'h40, 4'b0010};
        vt[13] = '{OP_SHL, 8'h01, 8'h07, 8'h80, 4'b0100};
        vt[14] = '{OP_SHR, 8'h80, 8'h07, 8'h01, 4'b0000};
        vt[15] = '{OP_SHL, 8'hC0, 8'h02, 8'h00, 4'b1010};

        rst_n = 1'b0; in_valid = 1'b0; op = OP_ADD; a = 8'h00; b = 8'h00;
        acc_sel = 1'b0; acc_clr = 1'b0; out_ready = 1'b1; oe = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_flags", {28'd0, flags}, 32'd0);
        chk("rst_y", {24'd0, y}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // first beat latency: visible exactly two edges after acceptance is offered
        beat(OP_ADD, 8'hF0, 8'h20, 1'b0);
        man_q.push_back('{8'h10, 4'b0010});
        step();
        in_valid = 1'b0;
        chk("lat_plus1_valid", {31'd0, out_valid}, 32'd0);
        step();
        chk("lat_plus2_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_plus2_y", {24'd0, y}, 32'h10);
        chk("lat_plus2_flags", {28'd0, flags}, 32'b0010);
        drain(10);

        // directed table, back to back
        foreach (vt[i]) begin
            beat(vt[i].op, vt[i].a, vt[i].b, 1'b0);
            man_q.push_back('{vt[i].ey, vt[i].ef});
            step();
        end
        in_valid = 1'b0;
        drain(20);

        // back-pressure: three beats while the consumer stalls
        out_ready = 1'b0;
        beat(vt[4].op, vt[4].a, vt[4].b, 1'b0);
        man_q.push_back('{vt[4].ey, vt[4].ef});
        chk("bp_rdy_beat1", {31'd0, in_ready}, 32'd1);
        step();
        beat(vt[8].op, vt[8].a, vt[8].b, 1'b0);
        man_q.push_back('{vt[8].ey, vt[8].ef});
        chk("bp_rdy_beat2", {31'd0, in_ready}, 32'd1);
        step();
        beat(vt[11].op, vt[11].a, vt[11].b, 1'b0);
        man_q.push_back('{vt[11].ey, vt[11].ef});
        chk("bp_rdy_beat3", {31'd0, in_ready}, 32'd0);
        repeat (3) step();
        chk("bp_rdy_held", {31'd0, in_ready}, 32'd0);
        chk("bp_held_count", exp_q.size(), 2);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        drain(10);
        chk("bp_man_used", man_q.size(), 0);

        // accumulator chain after clear
        acc_clr = 1'b1;
        step();
        acc_clr = 1'b0;
        model_acc = 8'h00;
        pop_cyc.delete();
        for (int i = 1; i <= 4; i++) begin
            beat(OP_ADD, 8'hEE, 8'd5, 1'b1);
            man_q.push_back('{8'(5 * i), 4'b0000});
            step();
        end
        in_valid = 1'b0;
        drain(10);
        chk("acc_pop_count", pop_cyc.size(), 4);
        for (int i = 1; i < 4 && i < pop_cyc.size(); i++)
            chk("acc_consecutive", pop_cyc[i] - pop_cyc[0], i);

        // clear coinciding with an acc_sel transfer: that beat sees 20, the next sees 0
        beat(OP_ADD, 8'h99, 8'd1, 1'b1);
        man_q.push_back('{8'd21, 4'b0000});
        step();
        acc_clr = 1'b1;
        beat(OP_ADD, 8'h99, 8'd2, 1'b1);
        man_q.push_back('{8'd2, 4'b0000});
        step();
        acc_clr = 1'b0;
        in_valid = 1'b0;
        acc_sel = 1'b0;
        drain(10);

        // reset with two beats in flight
        out_ready = 1'b0;
        beat(OP_SUB, 8'h7F, 8'hFF, 1'b0);
        man_q.push_back('{8'h80, 4'b0111});
        step();
        beat(OP_ADD, 8'h01, 8'h01, 1'b0);
        man_q.push_back('{8'h02, 4'b0000});
        step();
        in_valid = 1'b0;
        chk("midrst_pre_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_flags", {28'd0, flags}, 32'd0);
        exp_q.delete();
        man_q.delete();
        model_acc = 8'h00;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) step();
        chk("midrst_no_stale", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);

        // output enable low: y floats, handshake unaffected
        oe = 1'b0;
        beat(OP_OR, 8'h3C, 8'h00, 1'b0);
        man_q.push_back('{8'h3C, 4'b0000});
        step();
        in_valid = 1'b0;
        step();
        chk("oe_out_valid", {31'd0, out_valid}, 32'd1);
        chk("oe_y_float", {31'd0, ((y === 8'hzz) || (y === 8'h00))}, 32'd1);
        step();
        chk("oe_valid_drop", {31'd0, out_valid}, 32'd0);
        oe = 1'b1;

        // randomized traffic with random back-pressure and acc_sel
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            op        = 3'($urandom_range(0, 7));
            a         = 8'($urandom_range(0, 255));
            b         = 8'($urandom_range(0, 255));
            acc_sel   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain(50);
        step();
        chk("final_idle", {31'd0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
